// File: rtl/dice_turn_scheduler.sv
// Round-robin dice controller: shares one 3-bit LFSR die among PLAYERS requesters,
// latches and shows each roll, accumulates saturating scores and declares a winner.
module dice_turn_scheduler #(
  parameter int unsigned PLAYERS     = 4,
  parameter int unsigned TARGET      = 20,
  parameter int unsigned SHOW_CYCLES = 4,
  parameter int unsigned SCORE_W     = 6
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [PLAYERS-1:0]                i_roll,
  input  logic [$clog2(PLAYERS)-1:0]        i_score_sel,
  output logic [PLAYERS-1:0]                o_turn,
  output logic [7:0]                        o_display,
  output logic [2:0]                        o_value,
  output logic [SCORE_W-1:0]                o_score,
  output logic [PLAYERS-1:0]                o_winner,
  output logic                              o_game_over
);

  localparam int unsigned SEL_W = $clog2(PLAYERS);
  localparam int unsigned CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_ROLL = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  logic [1:0]         r_state, w_state;
  logic [PLAYERS-1:0] r_turn, w_turn;
  logic [2:0]         r_lfsr, w_lfsr;
  logic [7:0]         r_display, w_display;
  logic [2:0]         r_value, w_value;
  logic [PLAYERS-1:0] r_winner, w_winner;
  logic               r_game_over, w_game_over;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [SCORE_W-1:0] r_score [PLAYERS];

  logic [SEL_W-1:0]   w_cur;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_sat;
  logic               w_score_we;
  logic               w_win;

  function automatic logic [7:0] f_pattern(input logic [2:0] face);
    case (face)
      3'd1:    f_pattern = 8'b0000_0010;
      3'd2:    f_pattern = 8'b1001_0000;
      3'd3:    f_pattern = 8'b1001_0010;
      3'd4:    f_pattern = 8'b0110_1100;
      3'd5:    f_pattern = 8'b0111_1100;
      3'd6:    f_pattern = 8'b1111_1100;
      default: f_pattern = 8'b0000_0001;
    endcase
  endfunction

  // Next-state and next-register values.
  always_comb begin
    w_state     = r_state;
    w_turn      = r_turn;
    w_lfsr      = r_lfsr;
    w_display   = r_display;
    w_value     = r_value;
    w_winner    = r_winner;
    w_game_over = r_game_over;
    w_cnt       = r_cnt;
    w_score_we  = 1'b0;
    w_cur       = '0;
    for (int unsigned i = 0; i < PLAYERS; i++) begin
      if (r_turn[i]) w_cur = SEL_W'(i);
    end
    w_sum = {1'b0, r_score[w_cur]} + (SCORE_W+1)'(r_lfsr);
    w_sat = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
    w_win = 32'(r_score[w_cur]) >= TARGET;

    if (r_state != S_OVER) w_lfsr = {r_lfsr[1:0], r_lfsr[1] ^ r_lfsr[2]};

    case (r_state)
      S_WAIT: begin
        if (i_roll[w_cur]) w_state = S_ROLL;
      end
      S_ROLL: begin
        // Face 7 is not a die value; wait one cycle for the LFSR to move on to 6.
        if (!i_roll[w_cur] && r_lfsr != 3'd7 && r_lfsr != 3'd0) begin
          w_value    = r_lfsr;
          w_display  = f_pattern(r_lfsr);
          w_score_we = 1'b1;
          w_cnt      = CNT_W'(SHOW_CYCLES - 1);
          w_state    = S_SHOW;
        end
      end
      S_SHOW: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - CNT_W'(1);
        end else if (w_win) begin
          w_winner    = r_turn;
          w_game_over = 1'b1;
          w_state     = S_OVER;
        end else begin
          w_turn    = {r_turn[PLAYERS-2:0], r_turn[PLAYERS-1]};
          w_display = 8'h00;
          w_value   = 3'd0;
          w_state   = S_WAIT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= S_WAIT;
      r_turn      <= PLAYERS'(1);
      r_lfsr      <= 3'b100;
      r_display   <= 8'h00;
      r_value     <= 3'd0;
      r_winner    <= '0;
      r_game_over <= 1'b0;
      r_cnt       <= '0;
      for (int unsigned i = 0; i < PLAYERS; i++) r_score[i] <= '0;
    end else begin
      r_state     <= w_state;
      r_turn      <= w_turn;
      r_lfsr      <= w_lfsr;
      r_display   <= w_display;
      r_value     <= w_value;
      r_winner    <= w_winner;
      r_game_over <= w_game_over;
      r_cnt       <= w_cnt;
      if (w_score_we) r_score[w_cur] <= w_sat;
    end
  end

  assign o_turn      = r_turn;
  assign o_display   = r_display;
  assign o_value     = r_value;
  assign o_winner    = r_winner;
  assign o_game_over = r_game_over;
  assign o_score     = r_score[i_score_sel];

endmodule

// File: tb/tb_dice_turn_scheduler.sv
// Randomized bench for dice_turn_scheduler against a turn-level game model.
module tb_dice_turn_scheduler;

  localparam int unsigned PLAYERS     = 4;
  localparam int unsigned TARGET      = 20;
  localparam int unsigned SHOW_CYCLES = 4;
  localparam int unsigned SCORE_W     = 6;
  localparam int unsigned N_CYCLES    = 4000;

  logic               clk;
  logic               rst_n;
  logic [PLAYERS-1:0] roll;
  logic [1:0]         sel;
  logic [PLAYERS-1:0] turn;
  logic [7:0]         display;
  logic [2:0]         value;
  logic [SCORE_W-1:0] score;
  logic [PLAYERS-1:0] winner;
  logic               game_over;

  dice_turn_scheduler #(
    .PLAYERS(PLAYERS), .TARGET(TARGET), .SHOW_CYCLES(SHOW_CYCLES), .SCORE_W(SCORE_W)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_roll(roll), .i_score_sel(sel),
    .o_turn(turn), .o_display(display), .o_value(value), .o_score(score),
    .o_winner(winner), .o_game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference game state: die position in the 7-long face cycle, current player, scores.
  int die_seq [7] = '{4, 1, 2, 5, 3, 7, 6};
  int m_pos, m_player, m_face, m_show_left, m_winner;
  int m_score [PLAYERS];
  bit m_pressed, m_showing, m_over;
  int m_latched;

  function automatic logic [7:0] pips(input int face);
    case (face)
      1: return 8'b0000_0010;
      2: return 8'b1001_0000;
      3: return 8'b1001_0010;
      4: return 8'b0110_1100;
      5: return 8'b0111_1100;
      6: return 8'b1111_1100;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_player = 0; m_latched = 0; m_winner = -1;
    m_pressed = 0; m_showing = 0; m_over = 0; m_show_left = 0;
    for (int i = 0; i < PLAYERS; i++) m_score[i] = 0;
  endtask

  task automatic model_step(input bit rst, input logic [PLAYERS-1:0] r);
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_over) return;
    m_face = die_seq[m_pos];
    m_pos  = (m_pos + 1) % 7;
    if (m_showing) begin
      if (m_show_left > 1) m_show_left--;
      else if (m_score[m_player] >= TARGET) begin
        m_over = 1; m_winner = m_player;
      end else begin
        m_showing = 0; m_latched = 0;
        m_player = (m_player + 1) % PLAYERS;
      end
    end else if (!m_pressed) begin
      if (r[m_player]) m_pressed = 1;
    end else if (!r[m_player] && m_face != 7) begin
      m_pressed   = 0;
      m_showing   = 1;
      m_show_left = SHOW_CYCLES;
      m_latched   = m_face;
      m_score[m_player] = (m_score[m_player] + m_face > (1 << SCORE_W) - 1) ?
                          (1 << SCORE_W) - 1 : m_score[m_player] + m_face;
    end
  endtask

  task automatic compare_all();
    chk("turn",      32'(turn),      32'(1 << m_player));
    chk("display",   32'(display),   32'(pips(m_latched)));
    chk("value",     32'(value),     32'(m_latched));
    chk("score",     32'(score),     32'(m_score[sel]));
    chk("winner",    32'(winner),    m_over ? 32'(1 << m_winner) : 32'd0);
    chk("game_over", 32'(game_over), 32'(m_over));
  endtask

  initial begin
    bit rst_now;
    model_reset();
    rst_n = 1'b0;
    roll  = '0;
    sel   = 2'd0;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      rst_now = (cyc < 2) || ($urandom_range(0, 299) == 0);
      rst_n   = !rst_now;
      roll    = PLAYERS'($urandom_range(0, (1 << PLAYERS) - 1));
      sel     = 2'($urandom_range(0, PLAYERS - 1));
      @(posedge clk);
      model_step(rst_n, roll);
      #1;
      compare_all();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
